// File: rtl/prehisle_pkg.sv
// Shared types and widths for the main-CPU to sound-CPU command latch.
package prehisle_pkg;

  localparam int unsigned LATCH_DATA_W = 8;
  localparam int unsigned WAIT_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dtack_state_e;

endpackage

// File: rtl/sound_latch_if.sv
// Bus bundle between the 68000 and Z80 decode logic and the sound latch.
interface sound_latch_if;
  import prehisle_pkg::*;

  logic                    m68k_latch_cs;
  logic                    m68k_rw;
  logic                    m68k_lds_n;
  logic [LATCH_DATA_W-1:0] m68k_din;
  logic                    m68k_dtack_n;
  logic                    z80_latch_cs;
  logic                    z80_rd_n;
  logic [LATCH_DATA_W-1:0] z80_dout;
  logic                    z80_nmi_n;
  logic                    pending;
  logic                    overrun;

  modport master (
    output m68k_latch_cs, m68k_rw, m68k_lds_n, m68k_din, z80_latch_cs, z80_rd_n,
    input  m68k_dtack_n, z80_dout, z80_nmi_n, pending, overrun
  );

  modport slave (
    input  m68k_latch_cs, m68k_rw, m68k_lds_n, m68k_din, z80_latch_cs, z80_rd_n,
    output m68k_dtack_n, z80_dout, z80_nmi_n, pending, overrun
  );

endinterface

// File: rtl/edge_detect.sv
// One-bit registered history with rise/fall strobes; history resets to 1 so
// a level held high across reset release produces no edge.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!reset_n) d_q <= 1'b1;
    else          d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/sound_latch.sv
// 68000 -> Z80 command latch: byte capture, Z80 NMI request and 68000 DTACK.
module sound_latch
  import prehisle_pkg::*;
#(
  parameter int unsigned DTACK_WAIT = 2,
  parameter int unsigned NMI_PULSE  = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  sound_latch_if.slave bus
);

  localparam int unsigned NMI_CNT_W = (NMI_PULSE > 1) ? $clog2(NMI_PULSE + 1) : 1;

  logic wr, rd;
  logic wr_rise, wr_fall, rd_rise, rd_fall, cs_rise, cs_fall;
  logic unused_edges;

  assign wr = bus.m68k_latch_cs & ~bus.m68k_rw & ~bus.m68k_lds_n;
  assign rd = bus.z80_latch_cs & ~bus.z80_rd_n;

  edge_detect u_wr_edge (.clk(clk), .reset_n(reset_n), .d(wr),
                         .rise(wr_rise), .fall(wr_fall));
  edge_detect u_rd_edge (.clk(clk), .reset_n(reset_n), .d(rd),
                         .rise(rd_rise), .fall(rd_fall));
  edge_detect u_cs_edge (.clk(clk), .reset_n(reset_n), .d(bus.m68k_latch_cs),
                         .rise(cs_rise), .fall(cs_fall));

  assign unused_edges = ^{wr_fall, rd_rise, cs_fall};

  // Latch data and status; a capture beats a read-clear in the same cycle.
  logic [LATCH_DATA_W-1:0] dout_q;
  logic                    pending_q;
  logic                    overrun_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (wr_rise) begin
      dout_q    <= bus.m68k_din;
      pending_q <= 1'b1;
      if (pending_q && !rd_fall) overrun_q <= 1'b1;
    end else if (rd_fall) begin
      pending_q <= 1'b0;
    end
  end

  // NMI: level follows pending, or a reloadable N-cycle pulse per capture.
  logic [NMI_CNT_W-1:0] nmi_cnt_q;
  logic                 nmi_n_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nmi_cnt_q <= '0;
      nmi_n_q   <= 1'b1;
    end else if (NMI_PULSE == 0) begin
      nmi_n_q <= ~pending_q;
    end else if (wr_rise) begin
      nmi_cnt_q <= NMI_CNT_W'(NMI_PULSE);
      nmi_n_q   <= 1'b0;
    end else begin
      if (nmi_cnt_q != '0) nmi_cnt_q <= nmi_cnt_q - NMI_CNT_W'(1);
      nmi_n_q <= (nmi_cnt_q <= NMI_CNT_W'(1));
    end
  end

  // DTACK FSM state register.
  dtack_state_e          state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic                  dtack_n_q, dtack_n_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      dtack_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      dtack_n_q <= dtack_n_d;
    end
  end

  // DTACK FSM next state; a dropped select aborts from any state.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    dtack_n_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_rise) begin
          if (DTACK_WAIT == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            wait_d  = WAIT_CNT_W'(DTACK_WAIT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) state_d = ST_ACK;
        else              wait_d  = wait_q - WAIT_CNT_W'(1);
      end
      ST_ACK: begin
        state_d = ST_ACK;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!bus.m68k_latch_cs) begin
      state_d = ST_IDLE;
      wait_d  = '0;
    end
    dtack_n_d = (state_d != ST_ACK);
  end

  assign bus.z80_dout     = dout_q;
  assign bus.pending      = pending_q;
  assign bus.overrun      = overrun_q;
  assign bus.z80_nmi_n    = nmi_n_q;
  assign bus.m68k_dtack_n = dtack_n_q;

endmodule
